// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side master and its skid buffer.
package fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int CNT_W      = 16;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Words held after the coming edge, before any new read is issued.
  function automatic logic [2:0] occ_after(input logic [1:0] cnt,
                                           input logic       pend,
                                           input logic       pop);
    return {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry FIFO-ordered output buffer: head is always entry 0, pushes land at
// the tail, and a simultaneous push/pop shifts and writes on the same edge.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = SKID_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [1:0]       wr_idx;

  // The tail slot as seen after this edge's pop has shifted the entries.
  assign wr_idx     = count_reg - {1'b0, pop};
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == i[1:0])) begin
          mem_reg[i] <= din;
        end else if (pop && (i < DEPTH - 1)) begin
          mem_reg[i] <= mem_reg[(i < DEPTH - 1) ? i + 1 : i];
        end
      end
    end
  end

  assign head  = mem_reg[0];
  assign count = count_reg;

  // The read guard upstream must keep these unreachable.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_reg == 2'(DEPTH))));
  assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_reg == 2'd0)));

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the synchronous FIFO: issues r_en, absorbs the 1-cycle
// read latency and streams words out on valid/ready. Option: FIFO_READER_COUNT_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SKID  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_out,
  output logic             r_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  if (SKID != 2) begin : g_skid_check
    $error("fifo_reader: SKID must be 2");
  end

  rd_state_e  state_reg;
  rd_state_e  state_next;
  logic       rd_pend_reg;
  logic [1:0] buf_cnt;
  logic       pop;
  logic [2:0] occ_next;

  assign pop      = m_valid & m_ready;
  assign occ_next = occ_after(buf_cnt, rd_pend_reg, pop);

  // rst in the term forces the strobe low the instant reset asserts.
  assign r_en = en & ~empty & ~rst & (occ_next < 3'd2);

  fifo_reader_skid #(
    .WIDTH (WIDTH),
    .DEPTH (SKID)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend_reg),
    .din   (data_out),
    .pop   (pop),
    .head  (m_data),
    .count (buf_cnt)
  );

  assign m_valid = (buf_cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_pend_reg <= r_en;
    end
  end

  // With en low no read is issued, so occ_next is the data left after the edge.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!en) state_next = (occ_next != 3'd0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (en) begin
          state_next = RUN;
        end else if (occ_next == 3'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_W-1:0] xfer_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_reg <= '0;
    end else if (pop) begin
      xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`endif

  assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader with a queue-based FIFO model and an
// in-order scoreboard. Counter wrap test runs only with FIFO_READER_COUNT_EN.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] data_out = 8'h00;
  logic       r_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0] xfer_cnt;
`endif

  fifo_reader #(.WIDTH(8), .SKID(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .data_out (data_out),
    .r_en     (r_en),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .busy     (busy)
`ifdef FIFO_READER_COUNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // FIFO contents and the words it has handed out but the stream has not yet delivered.
  logic [7:0] fifo_q[$];
  logic [7:0] read_log[$];
  logic [7:0] rd_word;

  always @(posedge clk) begin
    if (r_en && fifo_q.size() > 0) begin
      rd_word = fifo_q.pop_front();
      data_out <= rd_word;
      read_log.push_back(rd_word);
    end
  end

  logic       s_r_en, s_valid, s_busy;
  logic [7:0] s_data;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         pop_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, edge follows.
  task automatic step(input logic en_i, input logic rdy_i);
    @(negedge clk);
    en      = en_i;
    m_ready = rdy_i;
    empty   = (fifo_q.size() == 0);
    #1;
    s_r_en  = r_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_busy  = busy;
    if (s_r_en) chk("r_en_when_empty", empty, 0);
    chk("outstanding_le2", read_log.size() <= 2, 1);
    if (prev_hold) begin
      chk("hold_valid", s_valid, 1);
      chk("hold_data", s_data, prev_data);
    end
    if (s_valid && m_ready) begin
      pop_cnt++;
      chk("pop_has_word", read_log.size() != 0, 1);
      if (read_log.size() != 0) chk("order", s_data, read_log.pop_front());
    end
    prev_hold = s_valid && !m_ready;
    prev_data = s_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    fifo_q.delete();
    read_log.delete();
    prev_hold = 1'b0;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_r_en;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[9];
  int   pulses, base, sent, tag;
  logic [7:0] exp_first;
  logic got_first;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h14};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h15};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset state
    #1;
    chk("rst_r_en", r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
`ifdef FIFO_READER_COUNT_EN
    chk("rst_xfer_cnt", xfer_cnt, 0);
`endif
    $display("test: reset state checked");

    // Five words, full throughput, two-clock first-word latency
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h11 + i));
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].en, tbl[k].rdy);
      chk($sformatf("vec%0d_r_en", k), s_r_en, tbl[k].exp_r_en);
      chk($sformatf("vec%0d_m_valid", k), s_valid, tbl[k].exp_valid);
      if (tbl[k].exp_valid) chk($sformatf("vec%0d_m_data", k), s_data, tbl[k].exp_data);
      $display("cycle %0d: r_en=%0b m_valid=%0b m_data=0x%0h", k, s_r_en, s_valid, s_data);
    end

    // Backpressure: only two reads, head held, then eight words with no gap
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h20 + i));
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0);
      if (s_r_en) pulses++;
      if (k >= 2) begin
        chk("bp_valid", s_valid, 1);
        chk("bp_head", s_data, 8'h20);
      end
    end
    chk("bp_r_en_pulses", pulses, 2);
    $display("backpressure: r_en pulses=%0d", pulses);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1);
      chk("bp_release_valid", s_valid, 1);
      chk("bp_release_data", s_data, 8'(8'h20 + k));
      $display("release %0d: m_data=0x%0h", k, s_data);
    end

    // Random m_ready and random FIFO fill over 100 words
    do_reset();
    base = pop_cnt;
    sent = 0;
    for (int c = 0; c < 3000 && (pop_cnt - base) < 100; c++) begin
      if (sent < 100 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(8'($urandom));
        sent++;
      end
      step(1'b1, 1'($urandom_range(0, 1)));
    end
    chk("rand_word_count", pop_cnt - base, 100);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
    chk("rand_no_extra", pop_cnt - base, 100);
    chk("rand_idle_valid", s_valid, 0);
    $display("random: delivered %0d words", pop_cnt - base);

    // en falls with one word in flight
    do_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h40 + i));
    base = pop_cnt;
    step(1'b1, 1'b0);
    chk("drain_first_r_en", s_r_en, 1);
    step(1'b0, 1'b0);
    chk("drain_no_r_en", s_r_en, 0);
    chk("drain_busy", s_busy, 1);
    step(1'b0, 1'b0);
    chk("drain_valid", s_valid, 1);
    chk("drain_data", s_data, 8'h40);
    chk("drain_busy2", s_busy, 1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1);
      chk("drain_no_r_en_late", s_r_en, 0);
      if (!s_busy) break;
    end
    chk("drain_idle_busy", s_busy, 0);
    chk("drain_idle_valid", s_valid, 0);
    chk("drain_word_count", pop_cnt - base, 1);
    chk("drain_fifo_left", fifo_q.size(), 3);
    $display("drain: delivered %0d word(s), fifo left %0d", pop_cnt - base, fifo_q.size());

    // Reset mid-stream discards buffered and in-flight words
    do_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h50 + i));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    chk("pre_rst_r_en", s_r_en, 1);
    chk("pre_rst_busy", s_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_r_en", r_en, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m_data", m_data, 0);
    @(negedge clk);
    en = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    read_log.delete();
    prev_hold = 1'b0;
    exp_first = fifo_q[0];
    rst = 1'b0;
    got_first = 1'b0;
    for (int c = 0; c < 10 && !got_first; c++) begin
      step(1'b1, 1'b1);
      if (s_valid) begin
        got_first = 1'b1;
        chk("post_rst_first", s_data, exp_first);
      end
    end
    chk("post_rst_got_word", got_first, 1);
    $display("reset mid-stream: first word after release 0x%0h", s_data);

`ifdef FIFO_READER_COUNT_EN
    // Counter wrap: 65535 pops, then 2 more
    do_reset();
    base = pop_cnt;
    for (int c = 0; c < 70000 && (pop_cnt - base) < 65535; c++) begin
      if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      step(1'b1, 1'b1);
    end
    step(1'b0, 1'b0);
    chk("cnt_pops_65535", pop_cnt - base, 65535);
    chk("cnt_ffff", xfer_cnt, 16'hFFFF);
    for (int c = 0; c < 20 && (pop_cnt - base) < 65537; c++) begin
      if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      step(1'b1, 1'b1);
    end
    step(1'b0, 1'b0);
    chk("cnt_wrap_0001", xfer_cnt, 16'h0001);
    $display("counter: xfer_cnt=0x%0h after %0d pops", xfer_cnt, pop_cnt - base);
`endif

    tag = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
